// File: rtl/ram_arbiter.sv
// ----------------------------------------------------------------------------
// ram_arbiter
//   Two-requester round-robin arbiter in front of a single simple dual-address
//   RAM. Each requester issues reads or writes over a valid/ready handshake.
//   At most one RAM access is made per cycle. Read data comes back one cycle
//   after the transfer, together with a one-cycle response pulse.
//
//   Optional feature (macro RAM_ARB_CLEAR_EN):
//     When the macro is defined, every reset starts a sweep that writes zero
//     to all `depth` RAM entries. No request is accepted during the sweep, and
//     `busy` is high while it runs. When the macro is undefined there is no
//     sweep: `busy` is tied low and requests are accepted in the first cycle
//     after reset.
//
// Ports
//   clk, rst                 single clock; synchronous active-high reset
//   reqNValid/Write/Addr/WrData   command from requester N (N = 0, 1)
//   reqNReady                accept strobe, combinational from the valids
//   rspNValid / rspNData     read response pulse and its data
//   wrEn/wrData/wrAdress     RAM write port
//   rdEn/rdAdress/rdData     RAM read port (rdData registered inside the RAM)
//   busy                     clear sweep in progress
// ----------------------------------------------------------------------------
module ram_arbiter #(
    parameter  int width = 8,
    parameter  int depth = 16,
    localparam int AW    = $clog2(depth)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0Valid,
    input  logic             req0Write,
    input  logic [AW-1:0]    req0Addr,
    input  logic [width-1:0] req0WrData,
    output logic             req0Ready,
    input  logic             req1Valid,
    input  logic             req1Write,
    input  logic [AW-1:0]    req1Addr,
    input  logic [width-1:0] req1WrData,
    output logic             req1Ready,
    output logic             rsp0Valid,
    output logic [width-1:0] rsp0Data,
    output logic             rsp1Valid,
    output logic [width-1:0] rsp1Data,
    output logic             wrEn,
    output logic [width-1:0] wrData,
    output logic [AW-1:0]    wrAdress,
    output logic             rdEn,
    output logic [AW-1:0]    rdAdress,
    input  logic [width-1:0] rdData,
    output logic             busy
);

    logic             w_clearing;   // sweep write this cycle
    logic             w_serve;      // arbitration allowed this cycle
    logic [AW-1:0]    w_clr_addr;
    logic             w_gnt;        // 0 = requester 0 selected, 1 = requester 1
    logic             w_xfer;
    logic             w_cmd_write;
    logic [AW-1:0]    w_cmd_addr;
    logic [width-1:0] w_cmd_data;

    logic             r_last_grant;
    logic             r_rsp0_valid;
    logic             r_rsp1_valid;

`ifdef RAM_ARB_CLEAR_EN
    typedef enum logic {S_CLEAR, S_SERVE} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_clr_cnt;

    // State register and sweep address counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_CLEAR) begin
                if (r_clr_cnt == AW'(depth - 1)) begin
                    r_clr_cnt <= '0;
                end else begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                end
            end
        end
    end

    // Next-state logic: leave the sweep after the write to the last entry
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_CLEAR: if (r_clr_cnt == AW'(depth - 1)) w_state_next = S_SERVE;
            S_SERVE: w_state_next = S_SERVE;
            default: w_state_next = S_SERVE;
        endcase
    end

    // The state register may hold any value while rst is high, so every
    // state-derived strobe is masked by rst.
    assign w_clearing = (r_state == S_CLEAR) & ~rst;
    assign w_serve    = (r_state == S_SERVE) & ~rst;
    assign w_clr_addr = r_clr_cnt;
`else
    assign w_clearing = 1'b0;
    assign w_serve    = ~rst;
    assign w_clr_addr = '0;
`endif

    // Round robin: on a tie pick the requester that did not win last time.
    assign w_gnt     = (req0Valid & req1Valid) ? ~r_last_grant : req1Valid;
    assign req0Ready = w_serve & req0Valid & ~w_gnt;
    assign req1Ready = w_serve & req1Valid &  w_gnt;
    assign w_xfer    = req0Ready | req1Ready;

    assign w_cmd_write = w_gnt ? req1Write  : req0Write;
    assign w_cmd_addr  = w_gnt ? req1Addr   : req0Addr;
    assign w_cmd_data  = w_gnt ? req1WrData : req0WrData;

    // Output logic: RAM command from the sweep or from the granted request
    always_comb begin
        wrEn     = 1'b0;
        wrData   = '0;
        wrAdress = '0;
        rdEn     = 1'b0;
        rdAdress = '0;
        if (w_clearing) begin
            wrEn     = 1'b1;
            wrAdress = w_clr_addr;
        end else if (w_xfer) begin
            if (w_cmd_write) begin
                wrEn     = 1'b1;
                wrAdress = w_cmd_addr;
                wrData   = w_cmd_data;
            end else begin
                rdEn     = 1'b1;
                rdAdress = w_cmd_addr;
            end
        end
    end

    // Grant history and read-response tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_last_grant <= w_gnt;
            end
            r_rsp0_valid <= req0Ready & ~req0Write;
            r_rsp1_valid <= req1Ready & ~req1Write;
        end
    end

    // A response still pending when reset arrives is dropped immediately.
    assign rsp0Valid = r_rsp0_valid & ~rst;
    assign rsp1Valid = r_rsp1_valid & ~rst;
    assign rsp0Data  = rdData;
    assign rsp1Data  = rdData;
    assign busy      = w_clearing;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int AW = 4;
`ifdef RAM_ARB_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0Valid = 1'b0, req0Write = 1'b0;
    logic [AW-1:0] req0Addr = '0;
    logic [W-1:0]  req0WrData = '0;
    logic          req1Valid = 1'b0, req1Write = 1'b0;
    logic [AW-1:0] req1Addr = '0;
    logic [W-1:0]  req1WrData = '0;
    logic          req0Ready, req1Ready;
    logic          rsp0Valid, rsp1Valid;
    logic [W-1:0]  rsp0Data, rsp1Data;
    logic          wrEn, rdEn, busy;
    logic [W-1:0]  wrData;
    logic [AW-1:0] wrAdress, rdAdress;
    logic [W-1:0]  rdData;

    int checks   = 0;
    int failures = 0;

    ram_arbiter #(.width(W), .depth(D)) dut (
        .clk(clk), .rst(rst),
        .req0Valid(req0Valid), .req0Write(req0Write), .req0Addr(req0Addr),
        .req0WrData(req0WrData), .req0Ready(req0Ready),
        .req1Valid(req1Valid), .req1Write(req1Write), .req1Addr(req1Addr),
        .req1WrData(req1WrData), .req1Ready(req1Ready),
        .rsp0Valid(rsp0Valid), .rsp0Data(rsp0Data),
        .rsp1Valid(rsp1Valid), .rsp1Data(rsp1Data),
        .wrEn(wrEn), .wrData(wrData), .wrAdress(wrAdress),
        .rdEn(rdEn), .rdAdress(rdAdress), .rdData(rdData),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // RAM stub driven by the DUT's RAM port
    logic [W-1:0] ram [D];
    always @(posedge clk) begin
        if (wrEn) ram[wrAdress] <= wrData;
        if (rdEn) rdData <= ram[rdAdress];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: remaining sweep cycles, who won last, which
    // requester has a read response due next cycle, and the RAM contents.
    // ------------------------------------------------------------------
    int           m_last = 1;
    int           m_clear_left = 0;
    int           m_pend = -1;
    logic [W-1:0] m_pend_data = '0;
    logic [W-1:0] m_mem [D];

    initial begin
        for (int i = 0; i < D; i++) begin
            ram[i]   = W'(i * 37 + 5);
            m_mem[i] = W'(i * 37 + 5);
        end
    end

    int           win;
    logic         e_r0, e_r1, e_we, e_re, e_busy, e_wr_cmd;
    logic [W-1:0] e_wd;
    logic [AW-1:0] e_wa, e_ra;

    always @(negedge clk) begin
        win = -1;
        e_r0 = 0; e_r1 = 0; e_we = 0; e_re = 0; e_busy = 0;
        e_wd = '0; e_wa = '0; e_ra = '0; e_wr_cmd = 0;
        if (!rst && m_clear_left > 0) begin
            e_busy = 1; e_we = 1; e_wa = AW'(D - m_clear_left);
        end else if (!rst) begin
            if (req0Valid && req1Valid) win = (m_last == 1) ? 0 : 1;
            else if (req0Valid)         win = 0;
            else if (req1Valid)         win = 1;
            if (win == 0) begin
                e_r0 = 1; e_wr_cmd = req0Write;
                if (req0Write) begin e_we = 1; e_wa = req0Addr; e_wd = req0WrData; end
                else begin e_re = 1; e_ra = req0Addr; end
            end else if (win == 1) begin
                e_r1 = 1; e_wr_cmd = req1Write;
                if (req1Write) begin e_we = 1; e_wa = req1Addr; e_wd = req1WrData; end
                else begin e_re = 1; e_ra = req1Addr; end
            end
        end
        chk("req0Ready", req0Ready, e_r0);
        chk("req1Ready", req1Ready, e_r1);
        chk("wrEn", wrEn, e_we);
        chk("wrAdress", wrAdress, e_wa);
        chk("wrData", wrData, e_wd);
        chk("rdEn", rdEn, e_re);
        chk("rdAdress", rdAdress, e_ra);
        chk("busy", busy, e_busy);
        chk("rsp0Valid", rsp0Valid, !rst && m_pend == 0);
        chk("rsp1Valid", rsp1Valid, !rst && m_pend == 1);
        if (!rst && m_pend == 0) chk("rsp0Data", rsp0Data, m_pend_data);
        if (!rst && m_pend == 1) chk("rsp1Data", rsp1Data, m_pend_data);
        // advance model to the next cycle
        if (rst) begin
            m_last = 1; m_pend = -1;
            m_clear_left = CLR_EN ? D : 0;
        end else if (m_clear_left > 0) begin
            m_mem[e_wa] = '0;
            m_clear_left--;
            m_pend = -1;
        end else begin
            m_pend = -1;
            if (win >= 0) begin
                m_last = win;
                if (e_wr_cmd) m_mem[e_wa] = e_wd;
                else begin m_pend = win; m_pend_data = m_mem[e_ra]; end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic set0(input logic v, input logic w, input int a, input int d);
        req0Valid = v; req0Write = w; req0Addr = AW'(a); req0WrData = W'(d);
    endtask

    task automatic set1(input logic v, input logic w, input int a, input int d);
        req1Valid = v; req1Write = w; req1Addr = AW'(a); req1WrData = W'(d);
    endtask

    logic acc0, acc1;

    initial begin
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        // reset-state check (still in reset)
        samp();
        chk("rst_ready0", req0Ready, 0);
        chk("rst_wrEn", wrEn, 0);
        chk("rst_busy", busy, 0);
        tick();
        rst = 0;
        // req0 asks to read addr 7 from the first cycle after reset
        set0(1, 0, 7, 0);
        if (CLR_EN) begin
            for (int i = 0; i < D; i++) begin
                samp();
                chk("sweep_busy", busy, 1);
                chk("sweep_wrEn", wrEn, 1);
                chk("sweep_addr", wrAdress, i);
                chk("sweep_data", wrData, 0);
                chk("sweep_ready0", req0Ready, 0);
                tick();
            end
        end
        samp();
        chk("first_busy", busy, 0);
        chk("first_ready0", req0Ready, 1);
        tick();
        set0(0, 0, 0, 0);
        samp();
        chk("rd7_valid", rsp0Valid, 1);
        chk("rd7_data", rsp0Data, CLR_EN ? 32'h00 : 32'h08);
        tick();

        // single requester: write then read
        set0(1, 1, 3, 8'hA5);
        samp();
        chk("s_ready0", req0Ready, 1);
        chk("s_wrAdress", wrAdress, 3);
        chk("s_wrData", wrData, 8'hA5);
        tick();
        set0(1, 0, 3, 0);
        samp();
        chk("s_rdEn", rdEn, 1);
        chk("s_rdAdress", rdAdress, 3);
        tick();
        set0(0, 0, 0, 0);
        samp();
        chk("s_rsp0Valid", rsp0Valid, 1);
        chk("s_rsp0Data", rsp0Data, 8'hA5);
        chk("s_rsp1Valid", rsp1Valid, 0);
        tick();
        samp();
        chk("s_rsp0_pulse", rsp0Valid, 0);
        tick();

        // contention: seed addr1/addr2, then both read for 6 cycles
        set0(1, 1, 1, 8'h11); tick(); set0(0, 0, 0, 0);
        set1(1, 1, 2, 8'h22); tick(); set1(0, 0, 0, 0);
        set0(1, 0, 1, 0);
        set1(1, 0, 2, 0);
        for (int i = 0; i < 7; i++) begin
            samp();
            if (i < 6) begin
                chk("c_ready0", req0Ready, (i % 2) == 0);
                chk("c_ready1", req1Ready, (i % 2) == 1);
            end
            if (i > 0) begin
                if (((i - 1) % 2) == 0) begin
                    chk("c_rsp0Valid", rsp0Valid, 1);
                    chk("c_rsp0Data", rsp0Data, 8'h11);
                end else begin
                    chk("c_rsp1Valid", rsp1Valid, 1);
                    chk("c_rsp1Data", rsp1Data, 8'h22);
                end
            end
            tick();
            if (i == 5) begin set0(0, 0, 0, 0); set1(0, 0, 0, 0); end
        end

        // back-to-back write/read on req1
        set1(1, 1, 15, 8'h3C); tick();
        set1(1, 0, 15, 0); tick();
        set1(0, 0, 0, 0);
        samp();
        chk("b2b_rsp1Valid", rsp1Valid, 1);
        chk("b2b_rsp1Data", rsp1Data, 8'h3C);
        tick();

        // reset in the cycle after a read transfer
        set0(1, 0, 3, 0); tick();
        set0(0, 0, 0, 0);
        set1(1, 1, 5, 8'h77);
        rst = 1;
        samp();
        chk("mr_rsp0Valid", rsp0Valid, 0);
        chk("mr_ready1", req1Ready, 0);
        chk("mr_wrEn", wrEn, 0);
        chk("mr_rdEn", rdEn, 0);
        tick();
        rst = 0;
        set1(0, 0, 0, 0);
        if (CLR_EN) begin
            samp();
            chk("mr_sweep_addr0", wrAdress, 0);
            chk("mr_sweep_busy", busy, 1);
            tick();
            repeat (D - 1) tick();
        end

        // withdrawn request
        set1(1, 0, 4, 0); tick(); set1(0, 0, 0, 0);
        set0(1, 0, 5, 0);
        set1(1, 1, 6, 8'h99);
        samp();
        chk("wd_ready0", req0Ready, 1);
        chk("wd_ready1", req1Ready, 0);
        tick();
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0);
        samp();
        chk("wd_wrEn", wrEn, 0);
        chk("wd_rdEn", rdEn, 0);
        tick();
        set0(1, 0, 5, 0);
        set1(1, 0, 6, 0);
        samp();
        chk("wd_tie_ready1", req1Ready, 1);
        chk("wd_tie_ready0", req0Ready, 0);
        tick();
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0);
        tick();

        // randomized traffic with occasional withdrawals and resets
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            acc0 = req0Valid && req0Ready;
            acc1 = req1Valid && req1Ready;
            @(posedge clk);
            #1;
            if (rst) rst = 0;
            else if ($urandom_range(0, 499) == 0) rst = 1;
            if (!req0Valid || acc0) begin
                req0Valid  = ($urandom_range(0, 2) != 0);
                req0Write  = 1'($urandom_range(0, 1));
                req0Addr   = AW'($urandom_range(0, D - 1));
                req0WrData = W'($urandom);
            end else if ($urandom_range(0, 7) == 0) begin
                req0Valid = 0;
            end
            if (!req1Valid || acc1) begin
                req1Valid  = ($urandom_range(0, 2) != 0);
                req1Write  = 1'($urandom_range(0, 1));
                req1Addr   = AW'($urandom_range(0, D - 1));
                req1WrData = W'($urandom);
            end else if ($urandom_range(0, 7) == 0) begin
                req1Valid = 0;
            end
        end
        rst = 0;
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin arbiter that shares one `Ram` instance (simple dual-address, single-clock RAM) between two requesters. Each requester issues read or write commands over a valid/ready handshake. The arbiter drives the RAM write and read ports and returns read data with a one-cycle response pulse. An optional post-reset sweep zero-fills the RAM before any request is accepted.

## Interface
Parameters:
- `width`, default 8: data width; must match the `Ram` instance.
- `depth`, default 16: RAM entries; address width `AW = $clog2(depth)`.

Ports:
- `clk`, input, 1: the single clock. All logic is on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req0Valid` / `req1Valid`, input, 1: command valid.
- `req0Write` / `req1Write`, input, 1: 1 = write, 0 = read.
- `req0Addr` / `req1Addr`, input, AW: command address.
- `req0WrData` / `req1WrData`, input, width: write data. Ignored for reads.
- `req0Ready` / `req1Ready`, output, 1: command accepted this cycle when high together with valid.
- `rsp0Valid` / `rsp1Valid`, output, 1: one-cycle pulse; read data is valid.
- `rsp0Data` / `rsp1Data`, output, width: read data, qualified by the matching `rspValid`.
- `wrEn`, output, 1: to `Ram.wrEn`.
- `wrData`, output, width: to `Ram.wrData`.
- `wrAdress`, output, AW: to `Ram.wrAdress`.
- `rdEn`, output, 1: to `Ram.rdEn`.
- `rdAdress`, output, AW: to `Ram.rdAdress`.
- `rdData`, input, width: from `Ram.rdData`. Registered by the RAM on the edge where `rdEn` is sampled high.
- `busy`, output, 1: high while the clear sweep runs; constant 0 when the sweep is compiled out.

## Operation
- States: `CLEAR` (present only with the macro) and `SERVE`. Reset enters `CLEAR` if compiled in, otherwise `SERVE`.
- `CLEAR`:
  - `wrEn = 1`, `wrData = 0`, `wrAdress = clrCnt`.
  - `clrCnt` runs 0 to depth-1, one address per cycle.
  - Both `Ready` outputs are 0.
  - After the write at depth-1, go to `SERVE`.
- `SERVE`: at most one RAM access per cycle.
  - If only one requester is valid, it gets the grant.
  - If both are valid, grant the requester that is not `lastGrant`.
  - `lastGrant` updates on every transfer (valid & ready). Its reset value is 1, so req0 wins the first tie.
- Grant and `Ready` are combinational from the valid inputs and `lastGrant`. Exactly one `Ready` is high when any valid is high in `SERVE`, and none when no valid is high.
- RAM command outputs are combinational from the granted request in the transfer cycle:
  - Write: `wrEn = 1`, `wrAdress = Addr`, `wrData = WrData`, `rdEn = 0`.
  - Read: `rdEn = 1`, `rdAdress = Addr`, `wrEn = 0`.
- When no transfer occurs, `wrEn` and `rdEn` are 0. `wrData`, `wrAdress` and `rdAdress` are driven to 0.
- Requesters hold Valid, Write, Addr and WrData stable until Ready. Dropping Valid before Ready withdraws the request; this is legal.
- Read response: `rspNValid` pulses for exactly one cycle, the cycle after the read transfer, to the requester that issued the read.
  - Both `rspNData` outputs are driven from `rdData`.
  - Writes produce no response.
- Back-to-back transfers are allowed every cycle. A read issued in the cycle after a write to the same address returns the new data.

## Timing
- Reset values: both `Ready` = 0, both `rspValid` = 0, `wrEn`/`rdEn` = 0, all addresses and `wrData` = 0, `lastGrant` = 1, `clrCnt` = 0.
- `busy` is 1 in the first cycle after reset when the sweep is enabled, and 0 otherwise.
- Read latency: transfer in cycle T gives `rspValid` and data in cycle T+1.
- Write: the RAM is updated at the rising edge that ends cycle T.
- Clear sweep: exactly `depth` cycles. The first `Ready` is possible in cycle `depth`, counting the first cycle after reset as cycle 0.
- Reset asserted mid-operation:
  - A pending `rspValid` is suppressed in the reset cycle.
  - The sweep restarts from address 0.
  - No RAM write is issued while `rst` is high.
- Fairness: under continuous contention, grants alternate 0,1,0,1…. Neither requester waits more than one cycle.

## Configuration
- `RAM_ARB_CLEAR_EN` defined: the `CLEAR` state and `clrCnt` are compiled in. The RAM reads all zeros after every reset, and `busy` works as described.
- `RAM_ARB_CLEAR_EN` undefined: no sweep, `busy` is tied to 0, and requests are accepted from the first cycle after reset. RAM contents are left untouched by reset.

## Test plan
- Clear sweep (macro on), depth 16:
  - Release reset.
  - Check 16 consecutive writes of 0 to addresses 0..15, with `busy` high for exactly 16 cycles.
  - A read of addr 7 afterwards returns 0x00.
- Single requester: req0 writes 0xA5 to addr 3, then reads addr 3.
  - `rsp0Valid` pulses one cycle after the read handshake with `rsp0Data` = 0xA5.
  - `rsp1Valid` stays 0.
- Contention: both requesters assert reads continuously (req0 addr 1, req1 addr 2) for 6 cycles.
  - Grants go 0,1,0,1,0,1.
  - Responses alternate with the correct data.
- Back-to-back: req1 writes 0x3C to addr 15 in cycle T and reads addr 15 in T+1.
  - Read data is 0x3C in T+2.
- Reset mid-operation: assert `rst` in the cycle after a read transfer.
  - `rsp0Valid` stays 0.
  - All outputs return to their reset values.
  - With the macro on, the sweep restarts at address 0.
- Withdrawn request: req1 asserts Valid while req0 is granted, then deasserts before Ready.
  - No RAM access is issued for req1, and `lastGrant` is unchanged by req1.
